plus_asic_unlock: RTL and testbench

//  Upstream of the Amstrad motherboard's Plus register inputs. Snoops Z80 I/O writes and runs the CPC+ ASIC unlock state machine.
//  The unlock sequence is written to the CRTC select port. Holds the ASIC-unlocked flag and the RMR2 ROM-mapping register.

---
 rtl/plus_asic_pkg.sv | 28 ++
 rtl/plus_unlock_rom.sv | 11 +
 rtl/plus_asic_unlock.sv | 113 +++++++++++
 tb/tb_plus_asic_unlock.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/plus_asic_pkg.sv
// plus_asic_pkg: shared constants and types for the CPC+ ASIC unlock logic
package plus_asic_pkg;

    localparam int         TAB_LEN  = 14;
    localparam logic [3:0] LAST_IDX = 4'd13;

    // Unlock byte sequence written to the CRTC select port, entry 0 first
    localparam logic [0:TAB_LEN-1][7:0] UNLOCK_TAB = {
        8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4, 8'h62,
        8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD
    };

    typedef enum logic [1:0] {
        WAIT_NZ,
        WAIT_ZERO,
        MATCH,
        FINAL
    } state_t;

    // CRTC select decode: A[14]==0 and A[9:8]
    localparam logic [1:0] CSEL_A98  = 2'b00;
    // RMR2 decode: A[15:14] and data tag D[7:5]
    localparam logic [1:0] RMR2_AHI  = 2'b01;
    localparam logic [2:0] RMR2_DTAG = 3'b101;
    // rmr2[4:3] value that maps the ASIC register page
    localparam logic [1:0] RMR2_ASIC = 2'b11;

endpackage

// File: rtl/plus_unlock_rom.sv
// plus_unlock_rom: combinational lookup of the unlock sequence byte by index
module plus_unlock_rom
    import plus_asic_pkg::*;
(
    input  logic [3:0] i_idx,
    output logic [7:0] o_byte
);

    assign o_byte = (i_idx <= LAST_IDX) ? UNLOCK_TAB[i_idx] : 8'h00;

endmodule

// File: rtl/plus_asic_unlock.sv
// plus_asic_unlock: snoops Z80 I/O writes, runs the CPC+ ASIC unlock FSM and holds RMR2
module plus_asic_unlock
    import plus_asic_pkg::*;
#(
    parameter logic [7:0] FINAL_BYTE = 8'hEE
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_plus_mode,
    input  logic        i_io_wr,
    input  logic [15:0] i_a,
    input  logic [7:0]  i_d,
    output logic        o_asic_unlocked,
    output logic        o_unlock_pulse,
    output logic [7:0]  o_rmr2,
    output logic        o_asic_page_en,
    output logic [3:0]  o_seq_idx
);

    logic       r_io_wr_q;
    state_t     r_state;
    logic [3:0] r_idx;
    logic       r_unlocked;
    logic       r_pulse;
    logic [7:0] r_rmr2;

    logic       w_event;
    logic       w_csel;
    logic       w_rmr2_wr;
    logic       w_zero;
    logic       w_final;
    logic       w_last;
    logic       w_tab_hit;
    logic [7:0] w_tab_byte;
    logic       w_unused;

    plus_unlock_rom u_rom (
        .i_idx  (r_idx),
        .o_byte (w_tab_byte)
    );

    // A long io_wr strobe yields a single event, on its rising edge only
    assign w_event   = i_io_wr & ~r_io_wr_q;
    assign w_csel    = w_event & ~i_a[14] & (i_a[9:8] == CSEL_A98);
    assign w_rmr2_wr = w_event & (i_a[15:14] == RMR2_AHI) & (i_d[7:5] == RMR2_DTAG) & r_unlocked;
    assign w_zero    = i_d == 8'h00;
    assign w_final   = i_d == FINAL_BYTE;
    assign w_last    = r_idx == LAST_IDX;
    assign w_tab_hit = i_d == w_tab_byte;
    assign w_unused  = &{1'b0, i_a[13:10], i_a[7:0]};

    // Registered copy of the write strobe for edge detection
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_io_wr_q <= 1'b0;
        else            r_io_wr_q <= i_io_wr;
    end

    // Unlock FSM, unlocked flag, unlock pulse and RMR2 register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= WAIT_NZ;
            r_idx      <= 4'd0;
            r_unlocked <= 1'b0;
            r_pulse    <= 1'b0;
            r_rmr2     <= 8'h00;
        end else if (!i_plus_mode) begin
            r_state    <= WAIT_NZ;
            r_idx      <= 4'd0;
            r_unlocked <= 1'b0;
            r_pulse    <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (w_rmr2_wr) r_rmr2 <= i_d;
            if (w_csel) begin
                case (r_state)
                    WAIT_NZ: begin
                        if (!w_zero) r_state <= WAIT_ZERO;
                    end
                    WAIT_ZERO: begin
                        if (w_zero) r_state <= MATCH;
                        r_idx <= 4'd0;
                    end
                    MATCH: begin
                        if (w_tab_hit) begin
                            r_state <= w_last ? FINAL : MATCH;
                            r_idx   <= w_last ? 4'd0 : r_idx + 4'd1;
                        end else begin
                            r_state <= w_zero ? MATCH : WAIT_ZERO;
                            r_idx   <= 4'd0;
                        end
                    end
                    FINAL: begin
                        r_unlocked <= w_final;
                        r_pulse    <= w_final & ~r_unlocked;
                        r_state    <= w_zero ? MATCH : WAIT_ZERO;
                        r_idx      <= 4'd0;
                    end
                    default: begin
                        r_state <= WAIT_NZ;
                        r_idx   <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign o_asic_unlocked = r_unlocked;
    assign o_unlock_pulse  = r_pulse;
    assign o_rmr2          = r_rmr2;
    assign o_seq_idx       = r_idx;
    assign o_asic_page_en  = r_unlocked & (r_rmr2[4:3] == RMR2_ASIC);

endmodule

// File: tb/tb_plus_asic_unlock.sv
// tb_plus_asic_unlock: table-driven, scoreboarded bench for the ASIC unlock block
module tb_plus_asic_unlock;

    localparam logic [15:0] CSEL = 16'hBC00;
    localparam logic [15:0] NC   = 16'h7F00;

    typedef struct {
        logic        pm;
        logic        wr;
        logic [15:0] a;
        logic [7:0]  d;
        int          hold;
        logic        unl;
        logic        pulse;
        logic [7:0]  rmr2;
        logic [3:0]  idx;
    } vec_t;

    typedef struct {
        logic       unl;
        logic       pulse;
        logic [7:0] rmr2;
        logic [3:0] idx;
        logic       page;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        plus_mode;
    logic        io_wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic        asic_unlocked;
    logic        unlock_pulse;
    logic [7:0]  rmr2;
    logic        asic_page_en;
    logic [3:0]  seq_idx;

    logic [7:0] tab [14] = '{8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4, 8'h62,
                             8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD};

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   pulse_cnt = 0;
    int   exp_pulses = 0;

    plus_asic_unlock dut (
        .i_clk           (clk),
        .i_reset_n       (reset_n),
        .i_plus_mode     (plus_mode),
        .i_io_wr         (io_wr),
        .i_a             (a),
        .i_d             (d),
        .o_asic_unlocked (asic_unlocked),
        .o_unlock_pulse  (unlock_pulse),
        .o_rmr2          (rmr2),
        .o_asic_page_en  (asic_page_en),
        .o_seq_idx       (seq_idx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (reset_n === 1'b1 && unlock_pulse === 1'b1) pulse_cnt++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic pm, input logic wr, input logic [15:0] aa, input logic [7:0] dd,
                                input int hold, input logic unl, input logic pulse, input logic [7:0] r2,
                                input logic [3:0] idx);
        vec_t v;
        v.pm = pm; v.wr = wr; v.a = aa; v.d = dd; v.hold = hold;
        v.unl = unl; v.pulse = pulse; v.rmr2 = r2; v.idx = idx;
        vecs.push_back(v);
    endfunction

    function automatic void cs(input logic [7:0] dd, input logic unl, input logic pulse,
                               input logic [7:0] r2, input logic [3:0] idx);
        add(1'b1, 1'b1, CSEL, dd, 0, unl, pulse, r2, idx);
    endfunction

    function automatic void tab_run(input int first, input int last, input logic track,
                                    input logic unl, input logic [7:0] r2);
        for (int i = first; i <= last; i++)
            cs(tab[i], unl, 1'b0, r2, track ? ((i == 13) ? 4'd0 : 4'(i + 1)) : 4'd0);
    endfunction

    initial begin
        reset_n = 1'b0; plus_mode = 1'b1; io_wr = 1'b0; a = 16'h0000; d = 8'h00;
        // first unlock from reset
        cs(8'h01, 0, 0, 8'h00, 0); cs(8'h00, 0, 0, 8'h00, 0);
        tab_run(0, 13, 1, 0, 8'h00); cs(8'hEE, 1, 1, 8'h00, 0);
        // re-unlock while unlocked: no pulse
        cs(8'h00, 1, 0, 8'h00, 0); tab_run(0, 13, 1, 1, 8'h00); cs(8'hEE, 1, 0, 8'h00, 0);
        // wrong final byte locks
        cs(8'h01, 1, 0, 8'h00, 0); cs(8'h00, 1, 0, 8'h00, 0);
        tab_run(0, 13, 1, 1, 8'h00); cs(8'hA5, 0, 0, 8'h00, 0);
        // RMR2 write while locked is ignored
        add(1, 1, NC, 8'hA3, 0, 0, 0, 8'h00, 0);
        // nonzero mismatch drops to WAIT_ZERO, table bytes then do nothing
        cs(8'h00, 0, 0, 8'h00, 0); tab_run(0, 2, 1, 0, 8'h00); cs(8'h33, 0, 0, 8'h00, 0);
        tab_run(0, 13, 0, 0, 8'h00); cs(8'hEE, 0, 0, 8'h00, 0);
        // zero mid-sequence resyncs to index 0
        cs(8'h00, 0, 0, 8'h00, 0); tab_run(0, 5, 1, 0, 8'h00); cs(8'h00, 0, 0, 8'h00, 0);
        tab_run(0, 13, 1, 0, 8'h00); cs(8'hEE, 1, 1, 8'h00, 0);
        // RMR2 write while unlocked
        add(1, 1, NC, 8'hB8, 0, 1, 0, 8'hB8, 0);
        // lock again
        cs(8'h00, 1, 0, 8'hB8, 0); tab_run(0, 13, 1, 1, 8'hB8); cs(8'hA5, 0, 0, 8'hB8, 0);
        // long strobe advances once; non-csel write in the middle is ignored
        cs(8'h00, 0, 0, 8'hB8, 0); add(1, 1, CSEL, 8'hFF, 19, 0, 0, 8'hB8, 1);
        tab_run(1, 6, 1, 0, 8'hB8); add(1, 1, NC, 8'h12, 0, 0, 0, 8'hB8, 7);
        tab_run(7, 13, 1, 0, 8'hB8); cs(8'hEE, 1, 1, 8'hB8, 0);
        // plus_mode=0 clears unlock/FSM, keeps rmr2, ignores events
        cs(8'h00, 1, 0, 8'hB8, 0); tab_run(0, 3, 1, 1, 8'hB8);
        add(0, 0, CSEL, 8'h00, 0, 0, 0, 8'hB8, 0);
        add(0, 1, CSEL, 8'h01, 0, 0, 0, 8'hB8, 0);
        add(0, 1, CSEL, 8'h00, 0, 0, 0, 8'hB8, 0);
        cs(8'h00, 0, 0, 8'hB8, 0); cs(8'hFF, 0, 0, 8'hB8, 0);
        cs(8'h00, 0, 0, 8'hB8, 0); cs(8'hFF, 0, 0, 8'hB8, 1);
        // unlock, then walk to index 9 for the async reset test
        tab_run(1, 13, 1, 0, 8'hB8); cs(8'hEE, 1, 1, 8'hB8, 0);
        cs(8'h00, 1, 0, 8'hB8, 0); tab_run(0, 8, 1, 1, 8'hB8);
        foreach (vecs[k]) exp_pulses += int'(vecs[k].pulse);

        repeat (3) @(negedge clk);
        chk("rst_held_idx", 32'(seq_idx), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_unlocked", 32'(asic_unlocked), 0);
        chk("rst_pulse", 32'(unlock_pulse), 0);
        chk("rst_rmr2", 32'(rmr2), 0);
        chk("rst_page_en", 32'(asic_page_en), 0);
        chk("rst_idx", 32'(seq_idx), 0);

        for (int k = 0; k < vecs.size(); k++) begin
            vec_t v;
            exp_t e;
            exp_t g;
            v = vecs[k];
            @(negedge clk);
            plus_mode = v.pm; a = v.a; d = v.d; io_wr = v.wr;
            e.unl = v.unl; e.pulse = v.pulse; e.rmr2 = v.rmr2; e.idx = v.idx;
            e.page = v.unl & (v.rmr2[4:3] == 2'b11);
            sb.push_back(e);
            @(negedge clk);
            g = sb.pop_front();
            chk($sformatf("v%0d_unlocked", k), 32'(asic_unlocked), 32'(g.unl));
            chk($sformatf("v%0d_pulse", k), 32'(unlock_pulse), 32'(g.pulse));
            chk($sformatf("v%0d_rmr2", k), 32'(rmr2), 32'(g.rmr2));
            chk($sformatf("v%0d_page_en", k), 32'(asic_page_en), 32'(g.page));
            chk($sformatf("v%0d_idx", k), 32'(seq_idx), 32'(g.idx));
            repeat (v.hold) @(negedge clk);
            io_wr = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_pulse_end", k), 32'(unlock_pulse), 0);
            chk($sformatf("v%0d_idx_hold", k), 32'(seq_idx), 32'(g.idx));
        end
        chk("pulse_count", 32'(pulse_cnt), 32'(exp_pulses));
        chk("pre_async_idx", 32'(seq_idx), 9);

        // async reset between edges must clear outputs before the next edge
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_unlocked", 32'(asic_unlocked), 0);
        chk("async_pulse", 32'(unlock_pulse), 0);
        chk("async_rmr2", 32'(rmr2), 0);
        chk("async_page_en", 32'(asic_page_en), 0);
        chk("async_idx", 32'(seq_idx), 0);
        #10 reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_async_idx", 32'(seq_idx), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
